// File: rtl/pkt_slot_buffer.sv
// Ring of fixed-size packet slots between the packet pipeline and the embedded processor.
// Slots move FREE -> FILL -> CPU (or OUT in bypass) -> OUT -> FREE, always in arrival order.
module pkt_slot_buffer #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH/8,
   parameter int SLOT_PW    = 2,
   parameter int SLOT_AW    = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [DATA_WIDTH-1:0]            in_data,
   input  logic [CTRL_WIDTH-1:0]            in_ctrl,
   input  logic                             in_wr,
   output logic                             in_rdy,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [CTRL_WIDTH-1:0]            out_ctrl,
   output logic                             out_wr,
   input  logic                             out_rdy,
   input  logic                             bypass_en,
   output logic                             cpu_pkt_valid,
   output logic [SLOT_AW:0]                 cpu_pkt_len,
   input  logic [SLOT_AW-1:0]               cpu_addr,
   input  logic                             cpu_we,
   input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] cpu_wdata,
   output logic [CTRL_WIDTH+DATA_WIDTH-1:0] cpu_rdata,
   input  logic                             cpu_len_we,
   input  logic [SLOT_AW:0]                 cpu_len,
   input  logic                             cpu_done,
   output logic [SLOT_PW:0]                 occupancy,
   output logic [15:0]                      drop_count
);
   localparam int NUM_SLOTS  = 1 << SLOT_PW;
   localparam int SLOT_WORDS = 1 << SLOT_AW;
   localparam int W          = CTRL_WIDTH + DATA_WIDTH;
   localparam int L          = SLOT_AW + 1;
   localparam logic [L-1:0] LEN_MAX = L'(SLOT_WORDS);

   typedef enum logic [1:0] {S_FREE, S_FILL, S_CPU, S_OUT} slot_st_t;

   logic [W-1:0]       r_mem [NUM_SLOTS*SLOT_WORDS];
   slot_st_t           r_state [NUM_SLOTS];
   logic [L-1:0]       r_len [NUM_SLOTS];
   logic [SLOT_PW-1:0] r_wr_ptr, r_cpu_ptr, r_rd_ptr;
   logic [L-1:0]       r_wr_idx, r_rd_idx;
   logic               r_trunc, r_last_zero, r_bypass;
   logic [SLOT_PW:0]   r_occ;
   logic [15:0]        r_drops;
   logic [W-1:0]       r_out, r_cpu_rdata;
   logic               r_out_wr;

   logic               w_accept, w_eop, w_full_idx, w_cpu_vld;
   logic [L-1:0]       w_len_clamp, w_len_eff, w_rd_len;
   logic               w_issue, w_rd_last, w_rd_empty, w_rd_skip;
   logic [SLOT_PW:0]   w_cnt;

   assign in_rdy      = !reset && (r_state[r_wr_ptr] == S_FREE || r_state[r_wr_ptr] == S_FILL);
   assign w_accept    = in_wr && in_rdy;
   // EOP is a non-zero ctrl word directly after a zero-ctrl word
   assign w_eop       = w_accept && (in_ctrl != '0) && r_last_zero;
   assign w_full_idx  = (r_wr_idx == LEN_MAX);

   assign w_cpu_vld   = !r_bypass && (r_state[r_cpu_ptr] == S_CPU);
   assign w_len_clamp = (cpu_len > LEN_MAX) ? LEN_MAX : cpu_len;
   assign w_len_eff   = cpu_len_we ? w_len_clamp : r_len[r_cpu_ptr];

   assign w_rd_len    = r_len[r_rd_ptr];
   assign w_issue     = (r_state[r_rd_ptr] == S_OUT) && out_rdy && (r_rd_idx < w_rd_len);
   assign w_rd_last   = w_issue && (r_rd_idx == w_rd_len - L'(1));
   assign w_rd_empty  = (r_state[r_rd_ptr] == S_OUT) && (w_rd_len == '0);
   // Slots released with length 0 go straight to FREE; the reader steps over them
   assign w_rd_skip   = (r_state[r_rd_ptr] == S_FREE) && (r_rd_ptr != r_cpu_ptr);

   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
         if (r_state[i] != S_FREE) w_cnt = w_cnt + (SLOT_PW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (w_accept && !w_full_idx)
         r_mem[{r_wr_ptr, r_wr_idx[SLOT_AW-1:0]}] <= {in_ctrl, in_data};
      if (!reset && w_cpu_vld && cpu_we)
         r_mem[{r_cpu_ptr, cpu_addr}] <= cpu_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_state[i] <= S_FREE;
            r_len[i]   <= '0;
         end
         r_wr_ptr    <= '0;
         r_cpu_ptr   <= '0;
         r_rd_ptr    <= '0;
         r_wr_idx    <= '0;
         r_rd_idx    <= '0;
         r_trunc     <= 1'b0;
         r_last_zero <= 1'b0;
         r_bypass    <= 1'b0;
         r_occ       <= '0;
         r_drops     <= '0;
         r_out       <= '0;
         r_out_wr    <= 1'b0;
         r_cpu_rdata <= '0;
      end else begin
         r_occ       <= w_cnt;
         r_cpu_rdata <= r_mem[{r_cpu_ptr, cpu_addr}];
         r_out_wr    <= w_issue;
         if (w_issue) r_out <= r_mem[{r_rd_ptr, r_rd_idx[SLOT_AW-1:0]}];
         if (w_cnt == '0) r_bypass <= bypass_en;

         if (w_accept) begin
            r_state[r_wr_ptr] <= S_FILL;
            r_last_zero       <= (in_ctrl == '0);
            if (w_full_idx) r_trunc <= 1'b1;
            else begin
               r_wr_idx          <= r_wr_idx + L'(1);
               r_len[r_wr_ptr]   <= r_wr_idx + L'(1);
            end
            if (w_eop) begin
               r_wr_idx    <= '0;
               r_trunc     <= 1'b0;
               r_last_zero <= 1'b0;
               if (r_trunc || w_full_idx) begin
                  r_state[r_wr_ptr] <= S_FREE;
                  if (r_drops != 16'hFFFF) r_drops <= r_drops + 16'd1;
               end else begin
                  r_state[r_wr_ptr] <= r_bypass ? S_OUT : S_CPU;
                  r_wr_ptr          <= r_wr_ptr + SLOT_PW'(1);
               end
            end
         end

         if (r_bypass) r_cpu_ptr <= r_wr_ptr;
         else if (w_cpu_vld) begin
            if (cpu_len_we) r_len[r_cpu_ptr] <= w_len_clamp;
            if (cpu_done) begin
               r_state[r_cpu_ptr] <= (w_len_eff == '0) ? S_FREE : S_OUT;
               r_cpu_ptr          <= r_cpu_ptr + SLOT_PW'(1);
            end
         end

         if (w_rd_empty || w_rd_last) begin
            r_state[r_rd_ptr] <= S_FREE;
            r_rd_idx          <= '0;
            r_rd_ptr          <= r_rd_ptr + SLOT_PW'(1);
         end else if (w_issue) r_rd_idx <= r_rd_idx + L'(1);
         else if (w_rd_skip) r_rd_ptr <= r_rd_ptr + SLOT_PW'(1);
      end
   end

   assign out_data      = r_out[DATA_WIDTH-1:0];
   assign out_ctrl      = r_out[W-1:DATA_WIDTH];
   assign out_wr        = r_out_wr;
   assign cpu_pkt_valid = w_cpu_vld;
   assign cpu_pkt_len   = w_cpu_vld ? r_len[r_cpu_ptr] : '0;
   assign cpu_rdata     = r_cpu_rdata;
   assign occupancy     = r_occ;
   assign drop_count    = r_drops;
endmodule
